uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_buffered.sv | 144 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and defaults for the buffered UART transmitter.
//   - tx_state_t   : serializer FSM state encoding
//   - *_DEF        : default BAUD_DIV / FIFO_DEPTH parameter values
//   - FRAME_BITS   : bits on the line per 8N1 frame (start + 8 data + stop)
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // 100 MHz sysclk / 115200 baud
  localparam int BAUD_DIV_DEF   = 868;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS     = 10;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock byte FIFO with occupancy count.
//   Ports:
//     sysclk, cpu_resetn : clock, async active-low reset
//     push, push_data    : append at tail; ignored when full (pre-edge)
//     pop, pop_data      : pop_data is the current head (combinational);
//                          pop advances the head, ignored when empty
//     full, empty, count : status derived from the registered count
//   The storage array is not reset; only pointers and count are.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = DATA_BITS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          sysclk,
  input  logic          cpu_resetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  // Both gates look at the pre-edge count, so a write arriving on a full
  // FIFO is dropped even if a pop frees a slot on the same edge.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   CPU-fed UART transmitter: byte FIFO in front of an 8N1 serializer.
//   Ports:
//     sysclk, cpu_resetn : clock, async active-low reset
//     wr_en, wr_data     : CPU store strobe and byte to queue
//     full               : FIFO holds FIFO_DEPTH bytes
//     busy               : FIFO non-empty or a frame on the line
//     overflow           : sticky, set by a write dropped on a full FIFO
//     uart_tx            : registered serial line, idle high, LSB first
//   A frame is START, 8 DATA bits, STOP, each BAUD_DIV cycles long.
//   The head byte is popped into a private shift register at frame start,
//   so later writes cannot disturb a frame already on the line.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       sysclk,
  input  logic       cpu_resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  tx_state_t   state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_q, tx_n;
  logic        pop;
  logic [7:0]  head;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        baud_end;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .push       (wr_en),
    .push_data  (wr_data),
    .pop        (pop),
    .pop_data   (head),
    .full       (full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign busy     = (fifo_count != '0) || (state != ST_IDLE);
  assign uart_tx  = tx_q;
  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Line value is computed one cycle ahead and registered, so uart_tx only
  // moves on the edge that starts a new state or bit.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 16'd1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = head;
          state_n = ST_START;
          tx_n    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = ST_DATA;
          tx_n    = shreg[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_n = '0;
          // Chain straight into the next start bit: no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_n = head;
            state_n = ST_START;
            tx_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  logic       sysclk = 1'b0;
  logic       cpu_resetn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, busy, overflow, uart_tx;

  int n_chk = 0;
  int n_bad = 0;

  // Per-cycle log of the line and busy, index 0 = cycle after the first pop.
  logic line [0:255];
  logic bz   [0:255];
  int   lidx = 0;
  bit   logging = 1'b0;
  logic [7:0] exp_b [0:7];

  uart_tx_buffered #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .busy       (busy),
    .overflow   (overflow),
    .uart_tx    (uart_tx)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
    if (logging && lidx < 256) begin
      line[lidx] = uart_tx;
      bz[lidx]   = busy;
      lidx++;
    end
  endtask

  task automatic do_reset();
    cpu_resetn = 1'b0;
    wr_en      = 1'b0;
    logging    = 1'b0;
    lidx       = 0;
    repeat (3) step();
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    cpu_resetn = 1'b1;
    step();
  endtask

  // Decode n back-to-back frames from the log against exp_b.
  task automatic check_frames(input string tag, input int n);
    for (int f = 0; f < n; f++) begin
      logic [7:0] d;
      int unst;
      int base;
      d = 8'h00;
      unst = 0;
      base = f * 40;
      for (int b = 0; b < 10; b++) begin
        logic v;
        v = line[base + b*4];
        for (int c = 1; c < 4; c++)
          if (line[base + b*4 + c] !== v) unst++;
        if (b >= 1 && b <= 8) d[b-1] = v;
      end
      chk($sformatf("%s_f%0d_start", tag, f), line[base], 0);
      chk($sformatf("%s_f%0d_stop", tag, f), line[base + 36], 1);
      chk($sformatf("%s_f%0d_stable", tag, f), unst, 0);
      chk($sformatf("%s_f%0d_data", tag, f), d, exp_b[f]);
    end
  endtask

  task automatic check_tail(input string tag, input int from, input int to);
    int lows;
    lows = 0;
    for (int i = from; i < to; i++) if (line[i] !== 1'b1) lows++;
    chk(tag, lows, 0);
  endtask

  initial begin
    // Idle after reset
    do_reset();
    begin
      int e_tx, e_busy, e_full, e_ovf;
      e_tx = 0; e_busy = 0; e_full = 0; e_ovf = 0;
      repeat (100) begin
        step();
        if (uart_tx !== 1'b1) e_tx++;
        if (busy !== 1'b0) e_busy++;
        if (full !== 1'b0) e_full++;
        if (overflow !== 1'b0) e_ovf++;
      end
      chk("idle_tx", e_tx, 0);
      chk("idle_busy", e_busy, 0);
      chk("idle_full", e_full, 0);
      chk("idle_ovf", e_ovf, 0);
    end

    // Single byte 0x55
    do_reset();
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    chk("t28_tx_before_pop", uart_tx, 1);
    chk("t28_busy_queued", busy, 1);
    logging = 1'b1;
    repeat (41) step();
    exp_b[0] = 8'h55;
    check_frames("t28", 1);
    chk("t28_busy_last", bz[39], 1);
    chk("t28_busy_fall", bz[40], 0);
    chk("t28_line_idle", line[40], 1);

    // Three back-to-back frames
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h41 + 8'(i);
      if (i == 1) logging = 1'b1;
      step();
    end
    wr_en = 1'b0;
    while (lidx < 141) step();
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    check_frames("t29", 3);
    chk("t29_busy_last", bz[119], 1);
    chk("t29_busy_fall", bz[120], 0);

    // Six writes, sixth dropped
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h10 + 8'(i);
      if (i == 1) logging = 1'b1;
      step();
      if (i == 4) begin
        chk("t30_full", full, 1);
        chk("t30_ovf_pre", overflow, 0);
      end
    end
    wr_en = 1'b0;
    chk("t30_ovf_set", overflow, 1);
    chk("t30_full_hold", full, 1);
    while (lidx < 220) step();
    for (int i = 0; i < 5; i++) exp_b[i] = 8'h10 + 8'(i);
    check_frames("t30", 5);
    check_tail("t30_no_6th", 200, 220);
    chk("t30_busy_fall", bz[200], 0);
    chk("t30_ovf_sticky", overflow, 1);

    // Write dropped on the STOP->START pop edge
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h20 + 8'(i);
      if (i == 1) logging = 1'b1;
      step();
    end
    wr_en = 1'b0;
    while (lidx < 40) step();
    chk("t31_full_pre", full, 1);
    chk("t31_ovf_pre", overflow, 0);
    wr_en = 1'b1; wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    chk("t31_nogap", line[40], 0);
    chk("t31_full_post", full, 0);
    chk("t31_ovf_post", overflow, 1);
    while (lidx < 220) step();
    for (int i = 0; i < 5; i++) exp_b[i] = 8'h20 + 8'(i);
    check_frames("t31", 5);
    check_tail("t31_no_extra", 200, 220);

    // Reset mid-frame, during data bit3 of 0xA5
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = (i == 0) ? 8'hA5 : (i == 1) ? 8'h11 : 8'h22;
      if (i == 1) logging = 1'b1;
      step();
    end
    wr_en = 1'b0;
    while (lidx < 18) step();
    chk("t32_bit3", uart_tx, 0);
    chk("t32_busy_pre", busy, 1);
    #2;
    cpu_resetn = 1'b0;
    #1;
    chk("t32_rst_tx", uart_tx, 1);
    chk("t32_rst_busy", busy, 0);
    chk("t32_rst_full", full, 0);
    logging = 1'b0;
    repeat (2) step();
    cpu_resetn = 1'b1;
    begin
      int e_tx, e_busy;
      e_tx = 0; e_busy = 0;
      repeat (100) begin
        step();
        if (uart_tx !== 1'b1) e_tx++;
        if (busy !== 1'b0) e_busy++;
      end
      chk("t32_post_tx", e_tx, 0);
      chk("t32_post_busy", e_busy, 0);
      chk("t32_post_ovf", overflow, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
